// File: rtl/regfile_access_sequencer.sv
// ---------------------------------------------------------------------------
// regfile_access_sequencer
//
// Purpose:
//   Steps a single instruction through its register-file access phases. On
//   in_start (sampled only while idle) the instruction word is latched and a
//   per-opcode sequence of one-cycle phases is walked. Each phase raises one
//   register-field select (gra/grb/grc) together with one access strobe
//   (read/write/base_addr_read). Loads and stores park in a memory-wait state
//   until in_mem_ready. Every sequence ends in a one-cycle DONE, except halt,
//   which parks in HALT until reset. Outputs are a pure decode of the current
//   state and the latched opcode (Moore).
//
// Ports:
//   in_clk              system clock, rising-edge active
//   in_rst              asynchronous, active-high reset
//   in_start            begin sequencing in_ir (ignored unless idle)
//   in_ir[31:0]         instruction word, opcode in [31:27]
//   in_mem_ready        memory cycle complete (looked at only in MEMW)
//   out_gra/grb/grc     register-field select strobes
//   out_read            register-file read strobe
//   out_write           register-file write strobe
//   out_base_addr_read  base-address read strobe
//   out_busy            high in every state except IDLE
//   out_done            one-cycle pulse at the end of a sequence
//   out_illegal         coincides with out_done for undefined opcodes
//   out_halted          high while halted
// ---------------------------------------------------------------------------
module regfile_access_sequencer (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_start,
    input  logic [31:0] in_ir,
    input  logic        in_mem_ready,
    output logic        out_gra,
    output logic        out_grb,
    output logic        out_grc,
    output logic        out_read,
    output logic        out_write,
    output logic        out_base_addr_read,
    output logic        out_busy,
    output logic        out_done,
    output logic        out_illegal,
    output logic        out_halted
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_P2   = 3'd2,
        S_MEMW = 3'd3,
        S_WB   = 3'd4,
        S_DONE = 3'd5,
        S_HALT = 3'd6
    } state_t;

    // Opcodes grouped by the shape of their access sequence. Every opcode in a
    // group walks exactly the same states with exactly the same strobes.
    typedef enum logic [3:0] {
        C_LD,      // ld:  base read, memory wait, write back
        C_LDI,     // ldi: base read, write back
        C_ST,      // st:  base read, data read, memory wait
        C_ALU3,    // three-register ALU: rb, rc read, ra write
        C_ALU2,    // two-operand ALU / immediate: rb read, ra write
        C_MULDIV,  // mul/div: rb, rc read, result goes to hi/lo
        C_RAREAD,  // br/jr/out: ra read only
        C_JAL,     // jal: ra read, link write via grb
        C_WBONLY,  // in/mfhi/mflo: ra write only
        C_NOP,
        C_HALT,
        C_ILLEGAL
    } op_class_t;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;

    // Only the opcode field steers the sequence; the operand fields are kept
    // in the latched word for completeness but not decoded here.
    logic unused_ir_fields;
    assign unused_ir_fields = ^ir_q[26:0];

    function automatic op_class_t op_class(input logic [4:0] op);
        op_class_t c;
        case (op)
            5'd0:                                 c = C_LD;
            5'd1:                                 c = C_LDI;
            5'd2:                                 c = C_ST;
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
            5'd9, 5'd10:                          c = C_ALU3;
            5'd11, 5'd12, 5'd13, 5'd16, 5'd17:    c = C_ALU2;
            5'd14, 5'd15:                         c = C_MULDIV;
            5'd18, 5'd19, 5'd22:                  c = C_RAREAD;
            5'd20:                                c = C_JAL;
            5'd21, 5'd23, 5'd24:                  c = C_WBONLY;
            5'd25:                                c = C_NOP;
            5'd26:                                c = C_HALT;
            default:                              c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    // Entry state for a freshly accepted instruction.
    function automatic state_t first_state(input op_class_t c);
        state_t s;
        case (c)
            C_WBONLY:           s = S_WB;
            C_NOP, C_ILLEGAL:   s = S_DONE;
            C_HALT:             s = S_HALT;
            default:            s = S_P1;
        endcase
        return s;
    endfunction

    function automatic state_t after_p1(input op_class_t c);
        state_t s;
        case (c)
            C_LD:                       s = S_MEMW;
            C_LDI, C_ALU2, C_JAL:       s = S_WB;
            C_ST, C_ALU3, C_MULDIV:     s = S_P2;
            default:                    s = S_DONE;
        endcase
        return s;
    endfunction

    function automatic state_t after_p2(input op_class_t c);
        state_t s;
        case (c)
            C_ST:       s = S_MEMW;
            C_ALU3:     s = S_WB;
            default:    s = S_DONE;
        endcase
        return s;
    endfunction

    // A load still has its write-back ahead; a store is finished.
    function automatic state_t after_memw(input op_class_t c);
        return (c == C_LD) ? S_WB : S_DONE;
    endfunction

    op_class_t cur_class;
    op_class_t new_class;
    assign cur_class = op_class(ir_q[31:27]);
    assign new_class = op_class(in_ir[31:27]);

    // State and latched instruction register.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= S_IDLE;
            ir_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state logic. The entry decision in IDLE looks at in_ir directly,
    // since the latched copy only becomes valid on the same edge.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    ir_d    = in_ir;
                    state_d = first_state(new_class);
                end
            end
            S_P1:   state_d = after_p1(cur_class);
            S_P2:   state_d = after_p2(cur_class);
            S_MEMW: begin
                if (in_mem_ready) begin
                    state_d = after_memw(cur_class);
                end
            end
            S_WB:   state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from state and latched opcode only.
    always_comb begin
        out_gra            = 1'b0;
        out_grb            = 1'b0;
        out_grc            = 1'b0;
        out_read           = 1'b0;
        out_write          = 1'b0;
        out_base_addr_read = 1'b0;
        out_busy           = (state_q != S_IDLE);
        out_done           = 1'b0;
        out_illegal        = 1'b0;
        out_halted         = 1'b0;
        case (state_q)
            S_P1: begin
                case (cur_class)
                    C_LD, C_LDI, C_ST: begin
                        out_grb            = 1'b1;
                        out_base_addr_read = 1'b1;
                    end
                    C_ALU3, C_ALU2, C_MULDIV: begin
                        out_grb  = 1'b1;
                        out_read = 1'b1;
                    end
                    default: begin
                        out_gra  = 1'b1;
                        out_read = 1'b1;
                    end
                endcase
            end
            S_P2: begin
                // A store reads its data register from the ra field.
                if (cur_class == C_ST) begin
                    out_gra = 1'b1;
                end else begin
                    out_grc = 1'b1;
                end
                out_read = 1'b1;
            end
            S_WB: begin
                // jal writes the link register through the grb path, which the
                // encode logic steers to R15.
                if (cur_class == C_JAL) begin
                    out_grb = 1'b1;
                end else begin
                    out_gra = 1'b1;
                end
                out_write = 1'b1;
            end
            S_DONE: begin
                out_done    = 1'b1;
                out_illegal = (cur_class == C_ILLEGAL);
            end
            S_HALT: begin
                out_halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_access_sequencer.sv
module tb_regfile_access_sequencer;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_start;
    logic [31:0] in_ir;
    logic        in_mem_ready;
    logic        out_gra, out_grb, out_grc;
    logic        out_read, out_write, out_base_addr_read;
    logic        out_busy, out_done, out_illegal, out_halted;

    regfile_access_sequencer dut (
        .in_clk             (in_clk),
        .in_rst             (in_rst),
        .in_start           (in_start),
        .in_ir              (in_ir),
        .in_mem_ready       (in_mem_ready),
        .out_gra            (out_gra),
        .out_grb            (out_grb),
        .out_grc            (out_grc),
        .out_read           (out_read),
        .out_write          (out_write),
        .out_base_addr_read (out_base_addr_read),
        .out_busy           (out_busy),
        .out_done           (out_done),
        .out_illegal        (out_illegal),
        .out_halted         (out_halted)
    );

    always #5 in_clk = ~in_clk;

    // Expected per-cycle output word: {gra,grb,grc,read,write,bar,done,illegal,halted}
    localparam logic [8:0] V_GRA  = 9'h100;
    localparam logic [8:0] V_GRB  = 9'h080;
    localparam logic [8:0] V_GRC  = 9'h040;
    localparam logic [8:0] V_RD   = 9'h020;
    localparam logic [8:0] V_WR   = 9'h010;
    localparam logic [8:0] V_BAR  = 9'h008;
    localparam logic [8:0] V_DONE = 9'h004;
    localparam logic [8:0] V_ILL  = 9'h002;
    localparam logic [8:0] V_HALT = 9'h001;
    localparam logic [8:0] V_MEMW = 9'h000;

    logic [8:0] exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    bit         end_req     = 1'b0;

    // Reference: the cycle-by-cycle output trace an opcode must produce.
    // w = cycles with in_mem_ready held low in MEMW (for halt: cycles held in HALT).
    task automatic build_trace(input logic [4:0] op, input int w,
                               output logic [8:0] tr[$], output int memw_first);
        int o;
        o = int'(op);
        tr.delete();
        memw_first = 0;
        if (o == 0) begin
            tr.push_back(V_GRB | V_BAR);
            memw_first = 2;
            repeat (w + 1) tr.push_back(V_MEMW);
            tr.push_back(V_GRA | V_WR);
        end else if (o == 1) begin
            tr.push_back(V_GRB | V_BAR);
            tr.push_back(V_GRA | V_WR);
        end else if (o == 2) begin
            tr.push_back(V_GRB | V_BAR);
            tr.push_back(V_GRA | V_RD);
            memw_first = 3;
            repeat (w + 1) tr.push_back(V_MEMW);
        end else if (o >= 3 && o <= 10) begin
            tr.push_back(V_GRB | V_RD);
            tr.push_back(V_GRC | V_RD);
            tr.push_back(V_GRA | V_WR);
        end else if ((o >= 11 && o <= 13) || o == 16 || o == 17) begin
            tr.push_back(V_GRB | V_RD);
            tr.push_back(V_GRA | V_WR);
        end else if (o == 14 || o == 15) begin
            tr.push_back(V_GRB | V_RD);
            tr.push_back(V_GRC | V_RD);
        end else if (o == 18 || o == 19 || o == 22) begin
            tr.push_back(V_GRA | V_RD);
        end else if (o == 20) begin
            tr.push_back(V_GRA | V_RD);
            tr.push_back(V_GRB | V_WR);
        end else if (o == 21 || o == 23 || o == 24) begin
            tr.push_back(V_GRA | V_WR);
        end
        if (o == 26)      repeat (w + 1) tr.push_back(V_HALT);
        else if (o >= 27) tr.push_back(V_DONE | V_ILL);
        else              tr.push_back(V_DONE);
    endtask

    // Issue one instruction. Entered and left 1 time unit after a rising edge.
    // abort_k > 0: reset is asserted early in cycle abort_k; -1: maybe random abort.
    task automatic run_txn(input logic [31:0] ir0, input int w, input int abort_k);
        logic [8:0] tr[$];
        int         memw_first;
        int         n;
        int         ak;
        build_trace(ir0[31:27], w, tr, memw_first);
        n  = tr.size();
        ak = abort_k;
        if (ir0[31:27] == 5'd26) ak = n;
        else if (ak < 0) ak = ($urandom_range(0, 5) == 0) ? $urandom_range(1, n) : 0;
        for (int i = 0; i < n; i++)
            if (ak == 0 || i < ak - 1) exp_q.push_back(tr[i]);
        in_ir        = ir0;
        in_start     = 1'b1;
        in_mem_ready = 1'($urandom);
        @(posedge in_clk); #1;
        for (int c = 1; c <= n; c++) begin
            if (c == ak) begin
                in_rst   = 1'b1;
                in_start = 1'b0;
                @(posedge in_clk); #1;
                in_rst = 1'b0;
                return;
            end
            in_start = 1'($urandom);
            in_ir    = $urandom;
            if (memw_first != 0 && c >= memw_first && c < memw_first + w)
                in_mem_ready = 1'b0;
            else if (memw_first != 0 && c == memw_first + w)
                in_mem_ready = 1'b1;
            else
                in_mem_ready = 1'($urandom);
            @(posedge in_clk); #1;
        end
        in_start = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            in_start     = 1'b0;
            in_ir        = $urandom;
            in_mem_ready = 1'($urandom);
            @(posedge in_clk); #1;
        end
    endtask

    // Stimulus
    initial begin
        logic [4:0] op;
        in_rst       = 1'b1;
        in_start     = 1'b0;
        in_ir        = 32'd0;
        in_mem_ready = 1'b0;
        repeat (3) @(posedge in_clk);
        #1 in_rst = 1'b0;

        run_txn(32'h18918000, 0, 0);                 // add R1,R2,R3
        idle(1);
        run_txn({5'd0, 27'h0123456}, 3, 0);          // ld, 3 wait cycles
        run_txn({5'd2, 27'h7654321}, 2, 0);          // st, 2 wait cycles
        run_txn({5'd20, 27'h00abcde}, 0, 0);         // jal
        run_txn({5'd26, 27'h0}, 4, 0);               // halt, then reset
        run_txn({5'd25, 27'h0}, 0, 0);               // nop
        run_txn({5'd31, 27'h0}, 0, 0);               // illegal
        run_txn({5'd27, 27'h1}, 0, 0);               // illegal, lowest code
        run_txn(32'h18918000, 0, 2);                 // add, reset in P2
        run_txn(32'h18918000, 0, 0);                 // add recovers
        run_txn({5'd0, 27'h0}, 2, 4);                // ld, reset in MEMW
        run_txn({5'd14, 27'h0}, 0, 0);               // mul
        run_txn({5'd21, 27'h0}, 0, 0);               // in

        for (int t = 0; t < 300; t++) begin
            op = 5'($urandom_range(0, 31));
            run_txn({op, 27'($urandom)}, $urandom_range(0, 4), -1);
            idle($urandom_range(0, 2));
        end
        idle(3);
        end_req = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        logic [8:0] act;
        logic [8:0] e;
        forever begin
            @(negedge in_clk);
            act = {out_gra, out_grb, out_grc, out_read, out_write,
                   out_base_addr_read, out_done, out_illegal, out_halted};
            vectors++;
            if (out_busy) begin
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_busy at %0t: got outputs %b, required busy=0", $time, act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        miscompares++;
                        $display("FAIL busy_cycle at %0t: got %b required %b", $time, act, e);
                    end
                end
            end else if (act !== 9'h000) begin
                miscompares++;
                $display("FAIL idle_outputs at %0t: got %b required %b", $time, act, 9'h000);
            end
            if (end_req) break;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: got %0d pending expected cycles, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
